// File: rtl/jtcop_obj_dma.sv
// Sprite-table DMA: copies CPU sprite RAM into a drawer-facing table buffer.
// Define JTCOP_OBJDMA_DBUF_EN for a double-buffered table with a bank swap in blanking.
module jtcop_obj_dma #(
  parameter int AW = 10,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          LVBL,
  input  logic          dma_trig,
  output logic          bus_req,
  input  logic          bus_ack,
  output logic [AW-1:0] ram_addr,
  input  logic [DW-1:0] ram_dout,
  input  logic [AW-1:0] tbl_addr,
  output logic [DW-1:0] tbl_dout,
  output logic          dma_busy,
  output logic          bank
);

`ifdef JTCOP_OBJDMA_DBUF_EN
  localparam int AB = AW + 1;
`else
  localparam int AB = AW;
`endif
  localparam logic [AW-1:0] ONE = 1;

  typedef enum logic [1:0] {IDLE, REQ, COPY, SWAP} state_t;

  state_t        r_state, w_next;
  logic          r_pending, r_last, r_vld;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_dout;
  logic [DW-1:0] r_mem [0:(1<<AB)-1];
  logic          w_rd, w_start;
  logic [AB-1:0] w_waddr, w_raddr;
`ifdef JTCOP_OBJDMA_DBUF_EN
  logic          r_bank, w_swap;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    bus_req  = 1'b0;
    w_rd     = 1'b0;
    w_start  = 1'b0;
    dma_busy = (r_state != IDLE);
`ifdef JTCOP_OBJDMA_DBUF_EN
    w_swap   = 1'b0;
`endif
    case (r_state)
      IDLE: if (r_pending && !LVBL) begin
        w_next  = REQ;
        w_start = 1'b1;
      end
      REQ: begin
        bus_req = 1'b1;
        if (bus_ack) w_next = COPY;
      end
      // r_last marks the cycle that only retires the final fetched word
      COPY: begin
        bus_req = !r_last;
        w_rd    = bus_ack && !r_last;
`ifdef JTCOP_OBJDMA_DBUF_EN
        if (r_last) w_next = SWAP;
`else
        if (r_last) w_next = IDLE;
`endif
      end
`ifdef JTCOP_OBJDMA_DBUF_EN
      SWAP: if (!LVBL) begin
        w_swap = 1'b1;
        w_next = IDLE;
      end
`endif
      default: w_next = IDLE;
    endcase
  end

  // A trigger seen while the previous one is consumed stays pending
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending <= 1'b0;
      r_last    <= 1'b0;
      r_vld     <= 1'b0;
      r_addr    <= '0;
    end else begin
      r_pending <= dma_trig | (r_pending & ~w_start);
      r_vld     <= w_rd;
      if (w_start) begin
        r_last <= 1'b0;
        r_addr <= '0;
      end else if (w_rd) begin
        r_addr <= r_addr + ONE;
        if (r_addr == {AW{1'b1}}) r_last <= 1'b1;
      end
    end
  end

`ifdef JTCOP_OBJDMA_DBUF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_bank <= 1'b0;
    else     r_bank <= r_bank ^ w_swap;
  end
  assign bank    = r_bank;
  assign w_waddr = {~r_bank, r_addr - ONE};
  assign w_raddr = {r_bank, tbl_addr};
`else
  assign bank    = 1'b0;
  assign w_waddr = r_addr - ONE;
  assign w_raddr = tbl_addr;
`endif

  // Write lags the read by one cycle, so its address is the already-advanced pointer minus one
  always_ff @(posedge clk) begin
    if (r_vld) r_mem[w_waddr] <= ram_dout;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_dout <= '0;
    else     r_dout <= r_mem[w_raddr];
  end

  assign tbl_dout = r_dout;
  assign ram_addr = r_addr;

endmodule

// File: tb/tb_jtcop_obj_dma.sv
// Directed testbench for jtcop_obj_dma; expectations adapt to JTCOP_OBJDMA_DBUF_EN.
module tb_jtcop_obj_dma;
  localparam int AW = 10;
  localparam int DW = 16;
  localparam int N  = 1 << AW;
`ifdef JTCOP_OBJDMA_DBUF_EN
  localparam bit DBUF = 1'b1;
`else
  localparam bit DBUF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, LVBL, dma_trig, bus_ack;
  logic          bus_req, dma_busy, bank;
  logic [AW-1:0] ram_addr, tbl_addr;
  logic [DW-1:0] ram_dout, tbl_dout;
  logic [DW-1:0] seed, frontSeed;
  logic          expBank;
  bit            ackRandom;
  int            testsRun = 0;
  int            testsFailed = 0;

  jtcop_obj_dma #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .LVBL(LVBL), .dma_trig(dma_trig),
    .bus_req(bus_req), .bus_ack(bus_ack), .ram_addr(ram_addr), .ram_dout(ram_dout),
    .tbl_addr(tbl_addr), .tbl_dout(tbl_dout), .dma_busy(dma_busy), .bank(bank)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pat(input int a, input logic [DW-1:0] s);
    logic [DW-1:0] t;
    t = a[DW-1:0];
    return t ^ s;
  endfunction

  // Sprite RAM model: synchronous read, one clock of latency
  always @(posedge clk) ram_dout <= pat(int'(ram_addr), seed);

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (ackRandom) bus_ack = ($urandom_range(0, 1) == 1);
  endtask

  task automatic applyStimulus();
    tick();
    dma_trig = 1'b1;
    tick();
    dma_trig = 1'b0;
  endtask

  task automatic waitIdle(input int budget, output int busyCnt, output bit ok);
    busyCnt = 0;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (dma_busy) busyCnt++;
      else if (busyCnt > 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic waitAddr(input int a, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (dma_busy && int'(ram_addr) == a) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic readTable(input logic [DW-1:0] s, output int bad);
    bad = 0;
    for (int i = 0; i < N; i++) begin
      tbl_addr = i[AW-1:0];
      tick();
      if (tbl_dout !== pat(i, s)) bad++;
    end
  endtask

  initial begin
    int  cnt, bad, rises, toggles;
    bit  ok, prevBusy, prevBank;

    rst = 1'b1; LVBL = 1'b1; dma_trig = 1'b0; bus_ack = 1'b0; tbl_addr = '0;
    seed = 16'hA5A5; frontSeed = '0; expBank = 1'b0; ackRandom = 1'b0;
    repeat (3) tick();
    checkOutput("rst_bus_req", bus_req, 0);
    checkOutput("rst_ram_addr", ram_addr, 0);
    checkOutput("rst_tbl_dout", tbl_dout, 0);
    checkOutput("rst_busy", dma_busy, 0);
    checkOutput("rst_bank", bank, 0);
    rst = 1'b0;
    bus_ack = 1'b1;

    // Trigger during active video waits for blanking
    applyStimulus();
    repeat (3) tick();
    checkOutput("wait_blank", bus_req, 0);
    LVBL = 1'b0;
    tick();
    checkOutput("req_rise", bus_req, 1);
    waitIdle(3000, cnt, ok);
    checkOutput("copy1_done", ok, 1);
    checkOutput("copy1_busy_len", cnt + 1, DBUF ? 1027 : 1026);
    expBank = expBank ^ DBUF;
    checkOutput("copy1_bank", bank, expBank);
    readTable(seed, bad);
    checkOutput("copy1_table_bad", bad, 0);
    frontSeed = seed;

    // Intermittent bus grant
    seed = 16'h3C5A;
    ackRandom = 1'b1;
    applyStimulus();
    waitIdle(8000, cnt, ok);
    ackRandom = 1'b0;
    bus_ack = 1'b1;
    checkOutput("rand_done", ok, 1);
    expBank = expBank ^ DBUF;
    checkOutput("rand_bank", bank, expBank);
    readTable(seed, bad);
    checkOutput("rand_table_bad", bad, 0);
    frontSeed = seed;

    // Copy runs into active video and finishes there
    seed = 16'h0F0F;
    applyStimulus();
    waitAddr(600, ok);
    checkOutput("mid_addr_seen", ok, 1);
    LVBL = 1'b1;
    tbl_addr = 10'd5;
    tick();
    checkOutput("mid_rd", tbl_dout, DBUF ? pat(5, frontSeed) : pat(5, seed));
    repeat (600) tick();
    checkOutput("hold_busy", dma_busy, DBUF);
    checkOutput("hold_bank", bank, expBank);
    tbl_addr = 10'd7;
    tick();
    checkOutput("hold_rd", tbl_dout, DBUF ? pat(7, frontSeed) : pat(7, seed));
    LVBL = 1'b0;
    tick();
    expBank = expBank ^ DBUF;
    checkOutput("fall_bank", bank, expBank);
    checkOutput("fall_busy", dma_busy, 0);
    tick();
    checkOutput("fall_rd", tbl_dout, pat(7, seed));
    readTable(seed, bad);
    checkOutput("late_table_bad", bad, 0);
    frontSeed = seed;

    // Three triggers during one copy yield exactly one more copy
    seed = 16'h1234;
    applyStimulus();
    waitAddr(100, ok);
    checkOutput("multi_addr_seen", ok, 1);
    for (int k = 0; k < 3; k++) begin
      applyStimulus();
      repeat (5) tick();
    end
    prevBusy = 1'b1; prevBank = bank; rises = 0; toggles = 0;
    for (int i = 0; i < 4000; i++) begin
      tick();
      if (dma_busy && !prevBusy) rises++;
      if (bank !== prevBank) toggles++;
      prevBusy = dma_busy;
      prevBank = bank;
    end
    checkOutput("multi_extra_copies", rises, 1);
    checkOutput("multi_toggles", toggles, DBUF ? 2 : 0);
    checkOutput("multi_busy_end", dma_busy, 0);
    readTable(seed, bad);
    checkOutput("multi_table_bad", bad, 0);

    // Reset in the middle of a copy
    seed = 16'h5A0F;
    applyStimulus();
    waitAddr(500, ok);
    checkOutput("abort_addr_seen", ok, 1);
    rst = 1'b1;
    #1;
    checkOutput("abort_bus_req", bus_req, 0);
    checkOutput("abort_busy", dma_busy, 0);
    checkOutput("abort_bank", bank, 0);
    tick();
    rst = 1'b0;
    expBank = 1'b0;
    seed = 16'hC3E1;
    applyStimulus();
    waitIdle(3000, cnt, ok);
    checkOutput("recopy_done", ok, 1);
    expBank = expBank ^ DBUF;
    checkOutput("recopy_bank", bank, expBank);
    readTable(seed, bad);
    checkOutput("recopy_table_bad", bad, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
